// File: rtl/k_symbol_framer_if.sv
// rtl/k_symbol_framer_if.sv - symbol/flag bundle between decoder side and framer (err_count only with FRAME_ERR_CNT_EN)
interface k_symbol_framer_if #(
  parameter int LANES = 1
);
  logic                 enb;
  logic [8*LANES-1:0]   rx_data_in;
  logic [8*LANES-1:0]   rx_data_out;
  logic [LANES-1:0]     k285;
  logic [LANES-1:0]     rx_ctrl;
  logic [LANES-1:0]     lock;
  logic [LANES-1:0]     pkt_valid;
  logic [LANES-1:0]     pkt_start;
  logic [LANES-1:0]     pkt_end;
  logic [LANES-1:0]     frame_err;
`ifdef FRAME_ERR_CNT_EN
  logic [16*LANES-1:0]  err_count;
`endif

  modport master (
    output enb,
    output rx_data_in,
    input  rx_data_out,
    input  k285,
    input  rx_ctrl,
    input  lock,
    input  pkt_valid,
    input  pkt_start,
    input  pkt_end,
    input  frame_err
`ifdef FRAME_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  enb,
    input  rx_data_in,
    output rx_data_out,
    output k285,
    output rx_ctrl,
    output lock,
    output pkt_valid,
    output pkt_start,
    output pkt_end,
    output frame_err
`ifdef FRAME_ERR_CNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/k_symbol_framer.sv
// rtl/k_symbol_framer.sv - per-lane K-symbol classify, COM lock FSM and STP/SDP..END/EDB framing; FRAME_ERR_CNT_EN adds err_count
module k_symbol_framer #(
  parameter int LANES    = 1,
  parameter int LOCK_CNT = 4,
  parameter int MAX_GAP  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  k_symbol_framer_if.slave       bus
);
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GAP_TO   = GW'(MAX_GAP + 1);
  localparam logic [CW-1:0] CNT_LOCK = CW'(LOCK_CNT);

  typedef enum logic [1:0] {S_LOS, S_ACQ, S_LOCKED} state_t;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      logic [7:0]    sym;
      logic [7:0]    data_q;
      state_t        state;
      logic [GW-1:0] gap;
      logic [GW-1:0] gap_next;
      logic [CW-1:0] com_cnt;
      logic          in_pkt;
      logic          k_q, ctrl_q, lock_q, pv_q, ps_q, pe_q, fe_q;
      logic          is_com, is_start, is_end, is_ctrl;
      logic          timeout, locked, fe_next;

      assign sym      = bus.rx_data_in[8*i +: 8];
      assign is_com   = (sym == 8'hBC);
      assign is_start = (sym == 8'hFB) || (sym == 8'h5C);
      assign is_end   = (sym == 8'hFD) || (sym == 8'hFE);
      assign is_ctrl  = is_com || is_start || is_end ||
                        (sym == 8'h1C) || (sym == 8'h3C) || (sym == 8'h7C);

      // Gap counter saturates one past MAX_GAP; reaching that value is the timeout
      assign gap_next = is_com ? '0 : ((gap == GAP_TO) ? gap : gap + 1'b1);
      assign timeout  = (gap_next == GAP_TO);
      assign locked   = (state == S_LOCKED);

      // Framing violations are only judged while the lane was locked before this symbol
      assign fe_next  = locked && (timeout  ? in_pkt  :
                                   is_start ? in_pkt  :
                                   is_end   ? !in_pkt :
                                   is_com   ? in_pkt  : 1'b0);

      // Lock FSM, framing state and all registered per-symbol flags
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          state   <= S_LOS;
          gap     <= '0;
          com_cnt <= '0;
          in_pkt  <= 1'b0;
          k_q     <= 1'b0;
          ctrl_q  <= 1'b0;
          lock_q  <= 1'b0;
          pv_q    <= 1'b0;
          ps_q    <= 1'b0;
          pe_q    <= 1'b0;
          fe_q    <= 1'b0;
        end else if (!bus.enb) begin
          ps_q <= 1'b0;
          pe_q <= 1'b0;
          fe_q <= 1'b0;
        end else begin
          data_q <= sym;
          k_q    <= is_com;
          ctrl_q <= is_ctrl;
          gap    <= gap_next;
          ps_q   <= 1'b0;
          pe_q   <= 1'b0;
          fe_q   <= fe_next;

          case (state)
            S_LOS: begin
              lock_q <= 1'b0;
              if (is_com) begin
                state   <= S_ACQ;
                com_cnt <= CW'(1);
              end
            end
            S_ACQ: begin
              if (is_com) begin
                com_cnt <= com_cnt + 1'b1;
                if (com_cnt + 1'b1 == CNT_LOCK) begin
                  state  <= S_LOCKED;
                  lock_q <= 1'b1;
                end else begin
                  lock_q <= 1'b0;
                end
              end else if (timeout) begin
                state   <= S_LOS;
                com_cnt <= '0;
                lock_q  <= 1'b0;
              end else begin
                lock_q <= 1'b0;
              end
            end
            S_LOCKED: begin
              if (timeout) begin
                state   <= S_LOS;
                com_cnt <= '0;
                lock_q  <= 1'b0;
              end else begin
                lock_q <= 1'b1;
              end
            end
            default: begin
              state  <= S_LOS;
              lock_q <= 1'b0;
            end
          endcase

          if (!locked || timeout) begin
            pv_q   <= 1'b0;
            in_pkt <= 1'b0;
          end else if (is_start) begin
            ps_q   <= 1'b1;
            pv_q   <= 1'b1;
            in_pkt <= 1'b1;
          end else if (is_end) begin
            pe_q   <= in_pkt;
            pv_q   <= in_pkt;
            in_pkt <= 1'b0;
          end else if (is_com) begin
            pv_q   <= 1'b0;
            in_pkt <= 1'b0;
          end else begin
            pv_q <= in_pkt;
          end
        end
      end

      assign bus.rx_data_out[8*i +: 8] = data_q;
      assign bus.k285[i]      = k_q;
      assign bus.rx_ctrl[i]   = ctrl_q;
      assign bus.lock[i]      = lock_q;
      assign bus.pkt_valid[i] = pv_q;
      assign bus.pkt_start[i] = ps_q;
      assign bus.pkt_end[i]   = pe_q;
      assign bus.frame_err[i] = fe_q;

`ifdef FRAME_ERR_CNT_EN
      logic [15:0] err_cnt;

      // Saturating count of frame_err pulses, cleared only by reset
      always_ff @(posedge clk) begin
        if (rst) begin
          err_cnt <= '0;
        end else if (bus.enb && fe_next && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end

      assign bus.err_count[16*i +: 16] = err_cnt;
`endif
    end
  endgenerate
endmodule
